// File: rtl/frac_block_sender.sv
// Transmit side of the QPEL fractional-search row interface: buffers one filter and one
// reference block, streams them row by row, then captures the returned motion vector.
// Optional build macro: FRAC_SENDER_CHECKSUM_EN adds a 14-bit pixel-sum output.
module frac_block_sender #(
    parameter int HEIGHT     = 8,
    parameter int RESULT_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [$clog2(HEIGHT)-1:0] wr_row,
    input  logic [63:0]               wr_data,
    input  logic                      start,
    output logic                      busy,
    output logic [63:0]               filter_pix,
    output logic [63:0]               ref_pix,
    output logic                      input_ready,
    input  logic [2:0]                mvx_in,
    input  logic [2:0]                mvy_in,
    output logic [2:0]                mvx,
    output logic [2:0]                mvy,
`ifdef FRAC_SENDER_CHECKSUM_EN
    output logic [13:0]               checksum,
`endif
    output logic                      done
);
    localparam int ROW_W = $clog2(HEIGHT);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d, row_nxt_s;
    logic [3:0]         lat_q, lat_d;
    logic [63:0]        filt_mem [HEIGHT];
    logic [63:0]        ref_mem  [HEIGHT];
    logic [63:0]        filter_pix_q, filter_pix_d, ref_pix_q, ref_pix_d;
    logic               busy_q, busy_d, ir_q, ir_d, done_q, done_d;
    logic [2:0]         mvx_q, mvx_d, mvy_q, mvy_d;
    logic               last_row_s, lat_end_s, accept_s, wr_ok_s;

    assign last_row_s = (row_q == ROW_W'(HEIGHT - 1));
    assign lat_end_s  = (lat_q == 4'(RESULT_LAT - 1));
    assign row_nxt_s  = row_q + ROW_W'(1);
    assign accept_s   = (state_q == IDLE) && start;
    assign wr_ok_s    = (state_q == IDLE) && wr_en;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEND; else state_d = IDLE;
            SEND:    if (last_row_s) state_d = WAIT; else state_d = SEND;
            WAIT:    if (lat_end_s) state_d = DONE; else state_d = WAIT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        filter_pix_d = 64'h0;
        ref_pix_d    = 64'h0;
        ir_d         = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        mvx_d        = mvx_q;
        mvy_d        = mvy_q;
        row_d        = '0;
        lat_d        = 4'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A row-0 write in the start cycle must reach the bus on T
                    filter_pix_d = (wr_en && !wr_sel && wr_row == '0) ? wr_data : filt_mem[0];
                    ref_pix_d    = (wr_en &&  wr_sel && wr_row == '0) ? wr_data : ref_mem[0];
                    ir_d         = 1'b1;
                    busy_d       = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            SEND: begin
                busy_d = 1'b1;
                if (!last_row_s) begin
                    filter_pix_d = filt_mem[row_nxt_s];
                    ref_pix_d    = ref_mem[row_nxt_s];
                    row_d        = row_nxt_s;
                end else begin
                    row_d = '0;
                end
            end
            WAIT: begin
                if (lat_end_s) begin
                    done_d = 1'b1;
                    mvx_d  = mvx_in;
                    mvy_d  = mvy_in;
                end else begin
                    busy_d = 1'b1;
                    lat_d  = lat_q + 4'd1;
                end
            end
            DONE:    busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            filter_pix_q <= 64'h0;
            ref_pix_q    <= 64'h0;
            ir_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mvx_q        <= 3'd0;
            mvy_q        <= 3'd0;
            row_q        <= '0;
            lat_q        <= 4'd0;
        end else begin
            filter_pix_q <= filter_pix_d;
            ref_pix_q    <= ref_pix_d;
            ir_q         <= ir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mvx_q        <= mvx_d;
            mvy_q        <= mvy_d;
            row_q        <= row_d;
            lat_q        <= lat_d;
        end
    end

    // Row buffers: host writes only while idle, never reset
    always_ff @(posedge clk) begin
        if (wr_ok_s && !wr_sel) begin
            filt_mem[wr_row] <= wr_data;
        end else if (wr_ok_s && wr_sel) begin
            ref_mem[wr_row] <= wr_data;
        end else begin
            filt_mem[0] <= filt_mem[0];
        end
    end

`ifdef FRAC_SENDER_CHECKSUM_EN
    logic [13:0] checksum_q, checksum_d;

    function automatic logic [13:0] row_sum(input logic [63:0] row);
        logic [13:0] acc;
        acc = 14'd0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + 14'(row[8*i +: 8]);
        end
        return acc;
    endfunction

    // Accumulate the rows currently on the bus during SEND
    always_comb begin
        checksum_d = checksum_q;
        if (accept_s) begin
            checksum_d = 14'd0;
        end else if (state_q == SEND) begin
            checksum_d = checksum_q + row_sum(filter_pix_q) + row_sum(ref_pix_q);
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= 14'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign busy        = busy_q;
    assign filter_pix  = filter_pix_q;
    assign ref_pix     = ref_pix_q;
    assign input_ready = ir_q;
    assign done        = done_q;
    assign mvx         = mvx_q;
    assign mvy         = mvy_q;
endmodule
